feature_pingpong_buf: RTL and testbench
=======================================

# feature_pingpong_buf

Parametrised feature-point store: the next generation of the lane feature buffer. It takes NUM_CH independent feature-point streams, one per region of interest, and stores each channel's points per frame into ping-pong banks. The Hough voting stage reads the completed previous frame while the current frame is being written. It sits between the feature-point extraction stage and the Hough accumulator.

## Interface
- COORD_W, 12, width of one x or y coordinate
- NUM_CH, 2, number of independent point channels (ROIs)
- DEPTH, 256, points stored per channel per bank; power of two
- ADDR_W, $clog2(DEPTH), read/write address width
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_sync  in  1  one-cycle pulse at frame start; swaps banks
- pt_de  in  NUM_CH  per-channel point valid
- pt_x  in  NUM_CH*COORD_W  channel c x coordinate at [c*COORD_W +: COORD_W]
- pt_y  in  NUM_CH*COORD_W  channel c y coordinate, same packing
- rd_en  in  1  read request
- rd_ch  in  $clog2(NUM_CH) (min 1)  channel to read
- rd_addr  in  ADDR_W  point index within the completed frame
- rd_vld  out  1  rd_data valid
- rd_data  out  2*COORD_W  {x, y} of the requested point
- rd_count  out  NUM_CH*(ADDR_W+1)  points stored per channel in the completed frame
- ovf  out  NUM_CH  per-channel overflow of the completed frame
- frame_rdy  out  1  high once at least one frame has completed

## Operation
- Each channel has two banks, A and B. wr_bank selects the bank being written; the other bank is the read bank. Reset sets wr_bank = A.
- A channel accepts a point when pt_de[c]=1 and pt_x != 0. x=0 marks an invalid coordinate and is never stored.
- Accepted point: stored at wr_ptr[c] in the write bank, then wr_ptr[c]++.
- Saturation: when wr_ptr[c]==DEPTH, further accepted points are dropped and ovf_acc[c] is set. There is no wrap-around and no overwrite.
- On frame_sync:
  - wr_bank toggles.
  - rd_count[c] <= wr_ptr[c], and ovf[c] <= ovf_acc[c].
  - wr_ptr and ovf_acc clear.
  - frame_rdy <= 1.
- frame_sync and an accepted point in the same cycle: the point belongs to the NEW frame. It is written to address 0 of the new write bank, and wr_ptr becomes 1.
- Read: on rd_en, bank = read bank of channel rd_ch.
  - If rd_addr < rd_count[rd_ch], rd_data = the stored point.
  - Otherwise rd_data = 0.
  - rd_vld = 1 in both cases.
- rd_ch >= NUM_CH: rd_data = 0, rd_vld = 1.
- frame_sync during an outstanding read: the read in flight returns data from the bank selected at request time.

## Timing
- Write: a point presented in cycle t is registered and written to RAM in cycle t+1. Total 2 clk, same as the existing store.
- Read latency is 1 clk: rd_en in cycle t gives rd_vld = 1 and rd_data in cycle t+1. rd_en may be asserted every cycle.
- rd_count, ovf and frame_rdy update in the cycle after frame_sync.
- Reset values:
  - rd_vld=0, rd_data=0, rd_count=0, ovf=0, frame_rdy=0
  - wr_ptr=0, ovf_acc=0, wr_bank=A
- RAM contents are not reset.
- rst_n asserted mid-frame: all pointers and counts clear immediately; any partial frame is discarded.

## Structure
- Package feature_pkg holds COORD_W and a packed point type {x, y}. It is shared with the extraction stage and the Hough stage.
- Sub-module feature_dpram: a simple dual-port RAM of width 2*COORD_W and depth 2*DEPTH with a registered read. The bank bit is the address MSB.
- One feature_dpram is instantiated per channel via generate.
- Top level contains the write pointers, bank control, count/overflow latches and the read mux.

## Test plan
- Frame basics: NUM_CH=2, DEPTH=256.
  - Stimulus: 5 points on ch0 (x=10..14, y=100), 3 points on ch1, then frame_sync.
  - Required: rd_count = {3, 5}, ovf=0, frame_rdy=1.
  - Reading ch0 addr 0..4 returns {10,100}..{14,100}, each 1 clk after rd_en.
- x=0 filter: pt_de=1 with x=0 for 4 cycles, then frame_sync → ch0 rd_count=0.
- Overflow: 300 points on ch0, then frame_sync.
  - Required: rd_count[ch0]=256, ovf[0]=1, addr 255 holds the 256th point.
  - Next frame with 2 points → ovf[0]=0.
- Ping-pong isolation:
  - Frame 1: points P1..P3 on ch1. Frame 2: write Q1..Q3 while reading ch1.
  - Required: reads during frame 2 return P1..P3, never Q.
  - After the next frame_sync, reads return Q1..Q3.
- Simultaneous event: point {20,30} coincident with frame_sync.
  - Required: it is stored at addr 0 of the new frame.
  - After the following frame_sync, rd_count includes it.
- Out-of-range and reset:
  - rd_addr >= rd_count → rd_data=0, rd_vld=1.
  - rst_n pulse mid-frame → rd_count=0, frame_rdy=0, rd_vld=0 the same cycle.

Source files
------------

// File: rtl/feature_pkg.sv
// Shared feature-point definitions for the extraction, buffer and Hough stages.
package feature_pkg;

    // Width of one x or y coordinate.
    localparam int COORD_W = 12;

    // One feature point, x in the upper half.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } point_t;

    // Ping-pong bank selector; the encoding is the RAM address MSB.
    typedef enum logic {
        BANK_A = 1'b0,
        BANK_B = 1'b1
    } bank_e;

    // Return the opposite bank.
    function automatic bank_e other_bank(input bank_e b);
        return (b == BANK_A) ? BANK_B : BANK_A;
    endfunction

endpackage

// File: rtl/feature_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Contents are not reset.
module feature_dpram #(
    parameter int DW = 24,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port, holds its last value when idle.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/feature_pingpong_buf.sv
// Per-channel ping-pong feature-point store. The current frame is written into
// one bank while the completed previous frame is read from the other.
import feature_pkg::*;

module feature_pingpong_buf #(
    parameter int COORD_W = feature_pkg::COORD_W,
    parameter int NUM_CH  = 2,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_sync,
    input  logic [NUM_CH-1:0]            pt_de,
    input  logic [NUM_CH*COORD_W-1:0]    pt_x,
    input  logic [NUM_CH*COORD_W-1:0]    pt_y,
    input  logic                         rd_en,
    input  logic [CH_W-1:0]              rd_ch,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_vld,
    output logic [2*COORD_W-1:0]         rd_data,
    output logic [NUM_CH*(ADDR_W+1)-1:0] rd_count,
    output logic [NUM_CH-1:0]            ovf,
    output logic                         frame_rdy
);

    localparam int            PW       = ADDR_W + 1;
    localparam int            DW       = 2 * COORD_W;
    localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);

    bank_e             wr_bank;
    bank_e             wr_bank_next;
    bank_e             rd_bank;

    logic [PW-1:0]     wr_ptr    [NUM_CH];
    logic              ovf_acc   [NUM_CH];
    logic [PW-1:0]     cnt_q     [NUM_CH];
    logic              ovf_q     [NUM_CH];

    logic              accept    [NUM_CH];
    logic              room      [NUM_CH];
    logic              wr_go     [NUM_CH];
    logic [ADDR_W-1:0] wr_loc    [NUM_CH];
    logic [DW-1:0]     wr_pt     [NUM_CH];

    logic              wr_en_q   [NUM_CH];
    logic [ADDR_W:0]   wr_addr_q [NUM_CH];
    logic [DW-1:0]     wr_data_q [NUM_CH];

    logic [DW-1:0]     ram_q     [NUM_CH];

    logic              rd_ch_valid;
    logic [CH_W-1:0]   ch_idx;
    logic              rd_ok;
    logic              rd_ok_q;
    logic [CH_W-1:0]   rd_ch_q;

    // A point arriving with frame_sync lands in the new bank at address 0.
    assign wr_bank_next = frame_sync ? other_bank(wr_bank) : wr_bank;
    assign rd_bank      = other_bank(wr_bank);

    // Per-channel accept/route decision for the incoming point.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            accept[c] = 1'b0;
            room[c]   = 1'b0;
            wr_go[c]  = 1'b0;
            wr_loc[c] = '0;
            wr_pt[c]  = '0;
            accept[c] = pt_de[c] && (pt_x[c*COORD_W +: COORD_W] != '0);
            room[c]   = (wr_ptr[c] != PTR_FULL);
            wr_go[c]  = accept[c] && (frame_sync || room[c]);
            wr_loc[c] = frame_sync ? '0 : wr_ptr[c][ADDR_W-1:0];
            wr_pt[c]  = {pt_x[c*COORD_W +: COORD_W], pt_y[c*COORD_W +: COORD_W]};
        end
    end

    // Bank toggle and frame-ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= BANK_A;
            frame_rdy <= 1'b0;
        end else if (frame_sync) begin
            wr_bank   <= other_bank(wr_bank);
            frame_rdy <= 1'b1;
        end
    end

    // Write pointers, overflow accumulation and completed-frame latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_ptr[c]  <= '0;
                ovf_acc[c] <= 1'b0;
                cnt_q[c]   <= '0;
                ovf_q[c]   <= 1'b0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (frame_sync) begin
                    cnt_q[c]   <= wr_ptr[c];
                    ovf_q[c]   <= ovf_acc[c];
                    wr_ptr[c]  <= accept[c] ? PW'(1) : '0;
                    ovf_acc[c] <= 1'b0;
                end else if (accept[c]) begin
                    if (room[c]) begin
                        wr_ptr[c] <= wr_ptr[c] + PW'(1);
                    end else begin
                        ovf_acc[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Write-stage registers feeding the RAM one cycle after the point arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_en_q[c]   <= 1'b0;
                wr_addr_q[c] <= '0;
                wr_data_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                wr_en_q[c]   <= wr_go[c];
                wr_addr_q[c] <= {wr_bank_next, wr_loc[c]};
                wr_data_q[c] <= wr_pt[c];
            end
        end
    end

    // Out-of-range channel check only exists when NUM_CH is not a power of two.
    generate
        if ((2 ** CH_W) == NUM_CH) begin : g_ch_full
            assign rd_ch_valid = 1'b1;
        end else begin : g_ch_part
            assign rd_ch_valid = ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH));
        end
    endgenerate

    assign ch_idx = rd_ch_valid ? rd_ch : '0;
    assign rd_ok  = rd_ch_valid && ({1'b0, rd_addr} < cnt_q[ch_idx]);

    // Read-side control; bank and range are fixed at request time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld  <= 1'b0;
            rd_ok_q <= 1'b0;
            rd_ch_q <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_ok_q <= rd_ok;
                rd_ch_q <= ch_idx;
            end
        end
    end

    assign rd_data = rd_ok_q ? ram_q[rd_ch_q] : '0;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            feature_dpram #(
                .DW (DW),
                .AW (ADDR_W + 1)
            ) u_ram (
                .clk   (clk),
                .we    (wr_en_q[c]),
                .waddr (wr_addr_q[c]),
                .wdata (wr_data_q[c]),
                .re    (rd_en),
                .raddr ({rd_bank, rd_addr}),
                .rdata (ram_q[c])
            );

            assign rd_count[c*PW +: PW] = cnt_q[c];
            assign ovf[c]               = ovf_q[c];
        end
    endgenerate

endmodule

// File: tb/tb_feature_pingpong_buf.sv
// Directed self-checking bench for feature_pingpong_buf.
import feature_pkg::*;

module tb_feature_pingpong_buf;

    localparam int CW     = feature_pkg::COORD_W;
    localparam int NCH    = 2;
    localparam int DEPTH  = 256;
    localparam int AW     = 8;
    localparam int PW     = AW + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  frame_sync = 1'b0;
    logic [NCH-1:0]        pt_de = '0;
    logic [NCH*CW-1:0]     pt_x = '0;
    logic [NCH*CW-1:0]     pt_y = '0;
    logic                  rd_en = 1'b0;
    logic [0:0]            rd_ch = '0;
    logic [AW-1:0]         rd_addr = '0;
    logic                  rd_vld;
    logic [2*CW-1:0]       rd_data;
    logic [NCH*PW-1:0]     rd_count;
    logic [NCH-1:0]        ovf;
    logic                  frame_rdy;

    int checks = 0;
    int errors = 0;

    feature_pingpong_buf #(
        .COORD_W (CW),
        .NUM_CH  (NCH),
        .DEPTH   (DEPTH),
        .ADDR_W  (AW),
        .CH_W    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_sync (frame_sync),
        .pt_de      (pt_de),
        .pt_x       (pt_x),
        .pt_y       (pt_y),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_addr    (rd_addr),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .rd_count   (rd_count),
        .ovf        (ovf),
        .frame_rdy  (frame_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pt(input int ch, input int x, input int y);
        pt_de[ch]            = 1'b1;
        pt_x[ch*CW +: CW]    = CW'(x);
        pt_y[ch*CW +: CW]    = CW'(y);
    endtask

    task automatic clr_pt();
        pt_de = '0;
        pt_x  = '0;
        pt_y  = '0;
    endtask

    task automatic push(input int ch, input int x, input int y);
        set_pt(ch, x, y);
        step();
        clr_pt();
    endtask

    task automatic fsync();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int ch, input int addr, input point_t exp);
        rd_en   = 1'b1;
        rd_ch   = 1'(ch);
        rd_addr = AW'(addr);
        step();
        rd_en   = 1'b0;
        check_val({tag, "_vld"}, 32'(rd_vld), 32'd1);
        check_val({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    function automatic point_t mkpt(input int x, input int y);
        point_t p;
        p.x = CW'(x);
        p.y = CW'(y);
        return p;
    endfunction

    function automatic logic [31:0] cnt2(input int c1, input int c0);
        logic [NCH*PW-1:0] v;
        v = {PW'(c1), PW'(c0)};
        return 32'(v);
    endfunction

    initial begin
        // Reset state
        repeat (3) step();
        check_val("rst_vld", 32'(rd_vld), 32'd0);
        check_val("rst_data", 32'(rd_data), 32'd0);
        check_val("rst_count", 32'(rd_count), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        check_val("rst_frdy", 32'(frame_rdy), 32'd0);
        rst_n = 1'b1;
        step();

        // Frame basics: 5 points on ch0, 3 on ch1
        for (int i = 0; i < 5; i++) begin
            set_pt(0, 10 + i, 100);
            if (i < 3) set_pt(1, 50 + i, 200);
            step();
            clr_pt();
        end
        check_val("pre_frdy", 32'(frame_rdy), 32'd0);
        fsync();
        check_val("basic_count", 32'(rd_count), cnt2(3, 5));
        check_val("basic_ovf", 32'(ovf), 32'd0);
        check_val("basic_frdy", 32'(frame_rdy), 32'd1);
        for (int i = 0; i < 5; i++) rd_chk("basic_rd0", 0, i, mkpt(10 + i, 100));
        rd_chk("basic_rd1", 1, 2, mkpt(52, 200));
        rd_chk("oor_ch0", 0, 5, '0);
        rd_chk("oor_ch1", 1, 3, '0);
        step();
        check_val("idle_vld", 32'(rd_vld), 32'd0);

        // x=0 filter
        for (int i = 0; i < 4; i++) push(0, 0, 77);
        fsync();
        check_val("x0_count", 32'(rd_count), cnt2(0, 0));
        rd_chk("x0_rd", 0, 0, '0);

        // Overflow: 300 points on ch0
        for (int i = 0; i < 300; i++) push(0, i + 1, i);
        fsync();
        check_val("ovf_count", 32'(rd_count), cnt2(0, 256));
        check_val("ovf_flag", 32'(ovf), 32'd1);
        rd_chk("ovf_first", 0, 0, mkpt(1, 0));
        rd_chk("ovf_last", 0, 255, mkpt(256, 255));
        push(0, 7, 8);
        push(0, 9, 10);
        fsync();
        check_val("ovf_clr", 32'(ovf), 32'd0);
        check_val("ovf_next_count", 32'(rd_count), cnt2(0, 2));
        rd_chk("ovf_next_rd", 0, 1, mkpt(9, 10));

        // Ping-pong isolation on ch1
        for (int i = 0; i < 3; i++) push(1, 100 + i, 1 + i);
        fsync();
        for (int i = 0; i < 3; i++) begin
            set_pt(1, 200 + i, 11 + i);
            rd_chk("pp_old", 1, i, mkpt(100 + i, 1 + i));
            clr_pt();
        end
        rd_chk("pp_old_again", 1, 0, mkpt(100, 1));
        fsync();
        check_val("pp_count", 32'(rd_count), cnt2(3, 0));
        for (int i = 0; i < 3; i++) rd_chk("pp_new", 1, i, mkpt(200 + i, 11 + i));

        // Point coincident with frame_sync belongs to the new frame
        set_pt(0, 20, 30);
        fsync();
        clr_pt();
        check_val("sim_prev_count", 32'(rd_count), cnt2(0, 0));
        push(0, 21, 31);
        fsync();
        check_val("sim_count", 32'(rd_count), cnt2(0, 2));
        rd_chk("sim_rd0", 0, 0, mkpt(20, 30));
        rd_chk("sim_rd1", 0, 1, mkpt(21, 31));

        // Read in flight across frame_sync returns the bank chosen at request
        push(0, 40, 41);
        rd_en = 1'b1; rd_ch = 1'b0; rd_addr = '0; frame_sync = 1'b1;
        step();
        rd_en = 1'b0; frame_sync = 1'b0;
        check_val("inflight_data", 32'(rd_data), 32'(mkpt(20, 30)));

        // Asynchronous reset mid-frame
        push(0, 60, 61);
        push(1, 62, 63);
        rd_en = 1'b1; rd_ch = 1'b0; rd_addr = '0;
        step();
        rd_en = 1'b0;
        check_val("pre_rst_vld", 32'(rd_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_vld", 32'(rd_vld), 32'd0);
        check_val("arst_count", 32'(rd_count), 32'd0);
        check_val("arst_frdy", 32'(frame_rdy), 32'd0);
        check_val("arst_data", 32'(rd_data), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        push(0, 70, 71);
        fsync();
        check_val("post_rst_count", 32'(rd_count), cnt2(0, 1));
        rd_chk("post_rst_rd", 0, 0, mkpt(70, 71));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
